// File: rtl/pulse_sequencer_pkg.sv
// Shared types and defaults for the pulse sequencer.
// Holds the FSM state encoding and the default counter width.
package pulse_sequencer_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: registered tick every div+1 enabled cycles.
// Ports: clk_i, reset_i, clear, enable, div in; hit (comb), tick (reg) out.
module tick_gen #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] div,
  output logic         hit,
  output logic         tick
);

  logic [W-1:0] presc;

  // hit is the edge that issues a tick; the tick itself shows next cycle
  assign hit = enable && (presc == div);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= hit;
      if (clear) begin
        presc <= '0;
      end else if (enable) begin
        presc <= (presc == div) ? '0 : presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_sequencer.sv
// Burst pulse sequencer: IDLE/RUN/DONE FSM around a tick prescaler.
// Ports: cfg handshake (valid/ready, div, count), start, abort; tick, busy, done, pulse_cnt out.
module pulse_sequencer
  import pulse_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [CNT_W-1:0] cfg_div_i,
  input  logic [CNT_W-1:0] cfg_count_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             tick_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] pulse_cnt_o
);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] pulse_cnt;
  logic [CNT_W-1:0] pc_next;
  logic             idle;
  logic             run;
  logic             go;
  logic             enable;
  logic             hit;
  logic             last;

  assign idle    = (state == IDLE);
  assign run     = (state == RUN);
  assign go      = idle && start_i;
  // abort suppresses the tick even when the prescaler matches
  assign enable  = run && !abort_i;
  assign pc_next = pulse_cnt + 1'b1;
  assign last    = (cnt_q != '0) && (pc_next == cnt_q);

  tick_gen #(
    .W(CNT_W)
  ) u_tick (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear  (go),
    .enable (enable),
    .div    (div_q),
    .hit    (hit),
    .tick   (tick_o)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start_i) state_n = RUN;
      RUN: begin
        if (abort_i) state_n = IDLE;
        else if (hit && last) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q     <= '0;
      cnt_q     <= CNT_W'(1);
      pulse_cnt <= '0;
    end else begin
      if (idle && cfg_valid_i) begin
        div_q <= cfg_div_i;
        cnt_q <= cfg_count_i;
      end
      if (go) pulse_cnt <= '0;
      else if (hit) pulse_cnt <= pc_next;
    end
  end

  assign cfg_ready_o = idle;
  assign busy_o      = run;
  assign done_o      = (state == DONE);
  assign pulse_cnt_o = pulse_cnt;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Self-checking bench for pulse_sequencer (16-bit and 4-bit instances).
// Vector table, directed corner sequences, and random stimulus vs a model.
module tb_pulse_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [15:0] div = '0;
  logic [15:0] cnt = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;

  logic        ready, tick, busy, done;
  logic [15:0] pc;
  logic        ready4, tick4, busy4, done4;
  logic [3:0]  pc4;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pulse_sequencer dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .cfg_valid_i(cfg_valid),
    .cfg_ready_o(ready),
    .cfg_div_i  (div),
    .cfg_count_i(cnt),
    .start_i    (start),
    .abort_i    (abort),
    .tick_o     (tick),
    .busy_o     (busy),
    .done_o     (done),
    .pulse_cnt_o(pc)
  );

  pulse_sequencer #(.CNT_W(4)) dut4 (
    .clk_i      (clk),
    .reset_i    (reset),
    .cfg_valid_i(cfg_valid),
    .cfg_ready_o(ready4),
    .cfg_div_i  (div[3:0]),
    .cfg_count_i(cnt[3:0]),
    .start_i    (start),
    .abort_i    (abort),
    .tick_o     (tick4),
    .busy_o     (busy4),
    .done_o     (done4),
    .pulse_cnt_o(pc4)
  );

  // Model: mode 0=idle 1=run 2=done; k counts run edges since start,
  // a tick is issued on every (div+1)-th of them.
  int m_mode[2];
  int m_k[2];
  int m_div[2];
  int m_cnt[2];
  int m_pc[2];
  bit m_tick[2];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int mask;
      mask = (i == 0) ? 32'hFFFF : 32'hF;
      if (reset) begin
        m_mode[i] = 0; m_k[i] = 0; m_div[i] = 0;
        m_cnt[i] = 1; m_pc[i] = 0; m_tick[i] = 0;
      end else begin
        case (m_mode[i])
          0: begin
            m_tick[i] = 0;
            if (cfg_valid) begin
              m_div[i] = int'(div) & mask;
              m_cnt[i] = int'(cnt) & mask;
            end
            if (start) begin
              m_mode[i] = 1; m_k[i] = 0; m_pc[i] = 0;
            end
          end
          1: begin
            m_k[i]++;
            if (abort) begin
              m_mode[i] = 0; m_tick[i] = 0;
            end else if (m_k[i] % (m_div[i] + 1) == 0) begin
              m_tick[i] = 1;
              m_pc[i] = (m_pc[i] + 1) & mask;
              if (m_cnt[i] != 0 && m_pc[i] == m_cnt[i]) m_mode[i] = 2;
            end else begin
              m_tick[i] = 0;
            end
          end
          default: begin
            m_tick[i] = 0; m_mode[i] = 0;
          end
        endcase
      end
    end
  endtask

  task automatic cmp_all();
    check("tick16", 32'(tick), 32'(m_tick[0]));
    check("busy16", 32'(busy), 32'(m_mode[0] == 1));
    check("done16", 32'(done), 32'(m_mode[0] == 2));
    check("ready16", 32'(ready), 32'(m_mode[0] == 0));
    check("pcnt16", 32'(pc), m_pc[0]);
    check("tick4", 32'(tick4), 32'(m_tick[1]));
    check("busy4", 32'(busy4), 32'(m_mode[1] == 1));
    check("done4", 32'(done4), 32'(m_mode[1] == 2));
    check("ready4", 32'(ready4), 32'(m_mode[1] == 0));
    check("pcnt4", 32'(pc4), m_pc[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp_all();
  endtask

  task automatic idle_in();
    reset = 0; cfg_valid = 0; start = 0; abort = 0;
  endtask

  typedef struct {
    bit rst, cv;
    int dv, ct;
    bit st, ab;
    bit tk, by, dn, rd;
    int pcv;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit rst, bit cv, int dv, int ct, bit st,
                              bit ab, bit tk, bit by, bit dn, bit rd,
                              int pcv);
    vec_t v;
    v.rst = rst; v.cv = cv; v.dv = dv; v.ct = ct; v.st = st; v.ab = ab;
    v.tk = tk; v.by = by; v.dn = dn; v.rd = rd; v.pcv = pcv;
    return v;
  endfunction

  initial begin
    int held;
    bit found;

    // default config div=0 count=1, then div=3 count=4 burst
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tv.push_back(mk(0, 1, 3, 4, 0, 0, 0, 0, 0, 1, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    tv.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 4));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 4));

    foreach (tv[i]) begin
      reset = tv[i].rst; cfg_valid = tv[i].cv;
      div = 16'(tv[i].dv); cnt = 16'(tv[i].ct);
      start = tv[i].st; abort = tv[i].ab;
      step();
      check($sformatf("vec%0d_tick", i), 32'(tick), 32'(tv[i].tk));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tv[i].by));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(tv[i].dn));
      check($sformatf("vec%0d_ready", i), 32'(ready), 32'(tv[i].rd));
      check($sformatf("vec%0d_pcnt", i), 32'(pc), tv[i].pcv);
    end
    idle_in();

    // config together with start: period 2, count 3
    cfg_valid = 1; div = 1; cnt = 3; start = 1;
    step();
    idle_in();
    step(); check("cs_tick_k1", 32'(tick), 0);
    step(); check("cs_tick_k2", 32'(tick), 1);
    check("cs_pcnt_k2", 32'(pc), 1);
    step(); check("cs_tick_k3", 32'(tick), 0);
    cfg_valid = 1; div = 0; cnt = 1;
    check("cs_ready_run", 32'(ready), 0);
    step(); check("cs_tick_k4", 32'(tick), 1);
    cfg_valid = 0;
    step(); check("cs_tick_k5", 32'(tick), 0);
    step(); check("cs_done_k6", 32'(done), 1);
    check("cs_pcnt_k6", 32'(pc), 3);
    step();

    // continuous div=2, abort on prescaler match
    cfg_valid = 1; div = 2; cnt = 0; start = 1;
    step();
    idle_in();
    repeat (20) step();
    found = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      if ((m_k[0] + 1) % 3 == 0) found = 1;
      else step();
    end
    check("ab_found_match", 32'(found), 1);
    held = m_pc[0];
    check("ab_held_cnt", held, (m_k[0] + 1) / 3 - 1);
    abort = 1;
    step();
    abort = 0;
    check("ab_tick", 32'(tick), 0);
    check("ab_done", 32'(done), 0);
    check("ab_ready", 32'(ready), 1);
    check("ab_pcnt", 32'(pc), held);
    step();
    check("ab_done_after", 32'(done), 0);

    // reset mid-burst after three ticks
    cfg_valid = 1; div = 5; cnt = 10; start = 1;
    step();
    idle_in();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (m_pc[0] == 3) found = 1;
    end
    check("rs_reached3", 32'(found), 1);
    step();
    reset = 1;
    step();
    reset = 0;
    check("rs_tick", 32'(tick), 0);
    check("rs_busy", 32'(busy), 0);
    check("rs_done", 32'(done), 0);
    check("rs_ready", 32'(ready), 1);
    check("rs_pcnt", 32'(pc), 0);
    start = 1;
    step();
    start = 0;
    step();
    check("rs_def_tick", 32'(tick), 1);
    check("rs_def_done", 32'(done), 1);
    check("rs_def_pcnt", 32'(pc), 1);
    step();

    // 4-bit wrap in continuous mode
    cfg_valid = 1; div = 0; cnt = 0; start = 1;
    step();
    idle_in();
    repeat (15) step();
    check("wr_pc4_15", 32'(pc4), 15);
    step();
    check("wr_pc4_0", 32'(pc4), 0);
    check("wr_tick4", 32'(tick4), 1);
    check("wr_busy4", 32'(busy4), 1);
    check("wr_pc16", 32'(pc), 16);
    abort = 1;
    step();
    abort = 0;

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      cfg_valid = ($urandom_range(0, 4) == 0);
      div       = 16'($urandom_range(0, 4));
      cnt       = 16'($urandom_range(0, 6));
      start     = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 39) == 0);
      step();
    end
    idle_in();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_sequencer.md
PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Interface
REQ-001 Parameter: CNT_W, default 16, width of the divisor, burst count and pulse counter.
REQ-002 Port: clk_i  input  1  single clock; all logic on its rising edge.
REQ-003 Port: reset_i  input  1  synchronous, active-high reset.
REQ-004 Port: cfg_valid_i  input  1  configuration offer.
REQ-005 Port: cfg_ready_o  output  1  configuration accepted when cfg_valid_i and cfg_ready_o are both high at a rising edge.
REQ-006 Port: cfg_div_i  input  CNT_W  divisor; tick period = cfg_div_i+1 cycles.
REQ-007 Port: cfg_count_i  input  CNT_W  ticks per burst; 0 = continuous.
REQ-008 Port: start_i  input  1  start a burst.
REQ-009 Port: abort_i  input  1  terminate a burst.
REQ-010 Port: tick_o  output  1  registered one-cycle tick.
REQ-011 Port: busy_o  output  1  high while in RUN.
REQ-012 Port: done_o  output  1  one-cycle completion pulse.
REQ-013 Port: pulse_cnt_o  output  CNT_W  ticks issued in the current or last burst.

Function
REQ-014 The state machine SHALL have states IDLE, RUN and DONE; reset SHALL enter IDLE.
REQ-015 cfg_ready_o SHALL equal (state==IDLE); in RUN/DONE cfg_valid_i SHALL be ignored and the held config SHALL be unchanged.
REQ-016 In IDLE, cfg_valid_i at edge E SHALL latch div_q and cnt_q at E.
REQ-017 In IDLE, start_i at edge E SHALL enter RUN at E and clear the prescaler counter and pulse_cnt_o; with cfg_valid_i at the same edge, the burst SHALL use the newly latched values.
REQ-018 In RUN, each cycle: if prescaler == div_q, tick_o SHALL be 1 next cycle and prescaler SHALL clear; else prescaler SHALL increment and tick_o SHALL be 0 next cycle.
REQ-019 Latency: start_i sampled at cycle T -> first tick_o high in cycle T+2+div_q, then every div_q+1 cycles; div_q=0 -> tick_o high every cycle.
REQ-020 pulse_cnt_o SHALL increment at the same edge tick_o is set, and SHALL wrap to 0 after all-ones in continuous mode.
REQ-021 With cnt_q!=0, the edge issuing the cnt_q-th tick SHALL move the state to DONE; the DONE cycle SHALL carry that last tick_o=1 and done_o=1.
REQ-022 DONE SHALL return to IDLE after exactly one cycle; busy_o SHALL be 0 in DONE.
REQ-023 With cnt_q==0, RUN SHALL continue until abort_i; done_o SHALL never assert.
REQ-024 abort_i in RUN SHALL move to IDLE at that edge, force tick_o to 0 next cycle even if the prescaler matched, not assert done_o, and leave pulse_cnt_o unchanged.
REQ-025 start_i in RUN/DONE and abort_i in IDLE/DONE SHALL be ignored.
REQ-026 Prescaler comparisons SHALL be unsigned, CNT_W bits wide, with no overflow beyond div_q.

Reset
REQ-027 reset_i SHALL set state=IDLE, tick_o=0, done_o=0, busy_o=0, pulse_cnt_o=0, prescaler=0, div_q=0 and cnt_q=1, so that cfg_ready_o=1 in the first cycle after reset.
REQ-028 reset_i SHALL override every other input, including mid-burst, at the same edge.

Structure
REQ-029 State encodings and the CNT_W default SHALL reside in the shared pulse_sequencer_pkg package/header.
REQ-030 The prescaler SHALL be a sub-module tick_gen (inputs clear and enable, divisor input, registered tick output), instantiated once.

Verification
REQ-031 Reset, no config, start at cycle 5 -> div=0, count=1: tick_o and done_o both high in cycle 7; IDLE in cycle 8.
REQ-032 cfg div=3, count=4, start at T -> tick_o high at T+5, T+9, T+13 and T+17; done_o high at T+17; pulse_cnt_o=4.
REQ-033 cfg_valid_i (div=1) with start_i at the same edge -> the burst uses div=1 (period 2); cfg_valid_i during RUN -> cfg_ready_o=0 and the burst is unchanged.
REQ-034 div=2, count=0, run 20 cycles, then abort on the cycle the prescaler equals 2 -> no tick_o in the following cycle, done_o stays 0, IDLE next cycle, pulse_cnt_o held.
REQ-035 reset_i asserted mid-burst (div=5, count=10, after 3 ticks) -> all outputs at reset values next cycle; a subsequent start uses div=0, count=1.
REQ-036 CNT_W=4, count=0, div=0 -> pulse_cnt_o wraps 15 -> 0 and tick_o stays continuous.
